// File: rtl/hist_equalizer_320x240.sv
// Frame-buffered histogram equalizer: captures one grayscale frame on a fixed input cadence,
// builds the cumulative histogram and remap table, then replays the remapped frame.
module hist_equalizer_320x240 #(
    parameter int N_PIX      = 76800,
    parameter int IN_PERIOD  = 14,
    parameter int IN_SAMPLE  = 8,
    parameter int OUT_FIRST  = 12,
    parameter int OUT_PERIOD = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] veri_i,
    output logic [7:0] veri_o,
    output logic       veri_al_o,
    output logic       veri_gonder_o,
    output logic       islem_bitti_o
);
    localparam int IW = $clog2(N_PIX + 1);
    localparam int AW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PIX - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(N_PIX);
    localparam logic [16:0]   N_PIX_C  = 17'(N_PIX);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_HIST_CDF, S_LUT, S_SEND, S_DONE
    } state_t;

    state_t            state_q;
    logic [15:0]       win_q, win_d, out_len;
    logic [IW-1:0]     idx_q;
    logic [255:0][16:0] hist_q;
    logic [8:0]        bin_q;
    logic [16:0]       acc_q, acc_d, cdf_min_q, cdf_cur, den, diff;
    logic              found_q;
    logic              div_busy_q;
    logic [3:0]        div_step_q;
    logic [25:0]       rem_q, num, cmp;
    logic [8:0]        quo_q, quo_d;
    logic              rem_ge;
    logic [1:0]        settle_q;
    logic [7:0]        veri_q;
    logic              gonder_q, bitti_q;
    logic              capture, uni, lut_we;
    logic [7:0]        lut_wdata;
    logic [AW-1:0]     rd_addr;

    logic [7:0]        buf_mem [N_PIX];
    logic [7:0]        lut_mem [256];
    logic [7:0]        buf_rd_q, lut_rd_q;

    always_comb begin
        win_d     = (win_q == 16'(IN_PERIOD - 1)) ? 16'd0 : win_q + 16'd1;
        capture   = (state_q == S_RECV) && (win_d == 16'(IN_SAMPLE)) && (idx_q != END_IDX);
        out_len   = (idx_q == '0) ? 16'(OUT_FIRST) : 16'(OUT_PERIOD);
        cdf_cur   = hist_q[bin_q[7:0]];
        acc_d     = acc_q + cdf_cur;
        uni       = (cdf_min_q == N_PIX_C);
        den       = N_PIX_C - cdf_min_q;
        // Bins below the first occupied one never appear in the frame; clamp them to 0.
        diff      = (cdf_cur > cdf_min_q) ? cdf_cur - cdf_min_q : 17'd0;
        num       = 26'(diff) * 26'd255;
        cmp       = 26'(den) << div_step_q;
        rem_ge    = (rem_q >= cmp);
        quo_d     = rem_ge ? (quo_q | (9'd1 << div_step_q)) : quo_q;
        lut_we    = (state_q == S_LUT) && !bin_q[8] && (uni || (div_busy_q && div_step_q == 4'd0));
        lut_wdata = uni ? bin_q[7:0] : (quo_d[8] ? 8'hFF : quo_d[7:0]);
        rd_addr   = '0;
        if (state_q == S_SEND && idx_q < LAST_IDX) begin
            rd_addr = AW'(idx_q + 1'b1);
        end
    end

    // Frame buffer and remap table: two chained registered reads prefetch the next output.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buf_mem[idx_q[AW-1:0]] <= veri_i;
        end
        buf_rd_q <= buf_mem[rd_addr];
        if (lut_we) begin
            lut_mem[bin_q[7:0]] <= lut_wdata;
        end
        lut_rd_q <= lut_mem[buf_rd_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            idx_q      <= '0;
            hist_q     <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            cdf_min_q  <= '0;
            found_q    <= 1'b0;
            div_busy_q <= 1'b0;
            div_step_q <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            settle_q   <= '0;
            veri_q     <= '0;
            gonder_q   <= 1'b0;
            bitti_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hist_q   <= '0;
                    gonder_q <= 1'b0;
                    bitti_q  <= 1'b0;
                    if (en_i) begin
                        state_q <= S_RECV;
                        win_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                S_RECV: begin
                    win_q <= win_d;
                    if (capture) begin
                        hist_q[veri_i] <= hist_q[veri_i] + 17'd1;
                        idx_q          <= idx_q + 1'b1;
                    end
                    if (idx_q == END_IDX) begin
                        state_q <= S_HIST_CDF;
                        bin_q   <= '0;
                        acc_q   <= '0;
                        found_q <= 1'b0;
                    end
                end
                S_HIST_CDF: begin
                    // Histogram is overwritten in place by the running cumulative sum.
                    hist_q[bin_q[7:0]] <= acc_d;
                    acc_q              <= acc_d;
                    if (!found_q && cdf_cur != 17'd0) begin
                        cdf_min_q <= acc_d;
                        found_q   <= 1'b1;
                    end
                    if (bin_q[7:0] == 8'hFF) begin
                        state_q    <= S_LUT;
                        bin_q      <= '0;
                        div_busy_q <= 1'b0;
                        settle_q   <= '0;
                    end else begin
                        bin_q <= bin_q + 9'd1;
                    end
                end
                S_LUT: begin
                    if (!bin_q[8]) begin
                        if (uni) begin
                            bin_q <= bin_q + 9'd1;
                        end else if (!div_busy_q) begin
                            rem_q      <= num;
                            quo_q      <= '0;
                            div_step_q <= 4'd8;
                            div_busy_q <= 1'b1;
                        end else begin
                            rem_q <= rem_ge ? rem_q - cmp : rem_q;
                            quo_q <= quo_d;
                            if (div_step_q == 4'd0) begin
                                div_busy_q <= 1'b0;
                                bin_q      <= bin_q + 9'd1;
                            end else begin
                                div_step_q <= div_step_q - 4'd1;
                            end
                        end
                    end else begin
                        // Let the last table write propagate through the read pipeline.
                        settle_q <= settle_q + 2'd1;
                        if (settle_q == 2'd2) begin
                            state_q  <= S_SEND;
                            veri_q   <= lut_rd_q;
                            gonder_q <= 1'b1;
                            bitti_q  <= 1'b1;
                            win_q    <= '0;
                            idx_q    <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (win_q == out_len - 16'd1) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= S_DONE;
                            gonder_q <= 1'b0;
                        end else begin
                            veri_q <= lut_rd_q;
                            idx_q  <= idx_q + 1'b1;
                            win_q  <= '0;
                        end
                    end else begin
                        win_q <= win_q + 16'd1;
                    end
                end
                S_DONE: begin
                    if (!en_i) begin
                        state_q <= S_IDLE;
                        bitti_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign veri_o        = veri_q;
    assign veri_gonder_o = gonder_q;
    assign islem_bitti_o = bitti_q;
    assign veri_al_o     = (state_q == S_IDLE) || (state_q == S_RECV);
endmodule

// File: tb/tb_hist_equalizer_320x240.sv
// Randomized bench for the histogram equalizer on a reduced frame, checked against an
// arithmetic reference of the equalization formula and the input/output cadence.
module tb_hist_equalizer_320x240;
    localparam int N   = 64;
    localparam int INP = 14;
    localparam int INS = 8;
    localparam int OF  = 12;
    localparam int OP  = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] vin;
    logic [7:0] vout;
    logic       al, gonder, bitti;

    int checks = 0;
    int errors = 0;
    logic [7:0] img  [N];
    logic [7:0] expv [N];

    always #5 clk = ~clk;

    hist_equalizer_320x240 #(
        .N_PIX(N), .IN_PERIOD(INP), .IN_SAMPLE(INS), .OUT_FIRST(OF), .OUT_PERIOD(OP)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .veri_i(vin), .veri_o(vout),
        .veri_al_o(al), .veri_gonder_o(gonder), .islem_bitti_o(bitti)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, "_veri_o"}, 32'(vout), 0);
        check_eq({where, "_gonder"}, 32'(gonder), 0);
        check_eq({where, "_bitti"}, 32'(bitti), 0);
        check_eq({where, "_veri_al"}, 32'(al), 1);
    endtask

    task automatic fill(input int mode);
        int j;
        logic [7:0] t;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: img[k] = 8'd100;
                1: img[k] = 8'(k % 4);
                2: img[k] = (k < N / 2) ? 8'd0 : 8'd255;
                3: img[k] = 8'($urandom_range(255, 0));
                4: img[k] = 8'($urandom_range(103, 100));
                default: img[k] = 8'd50;
            endcase
        end
        if (mode == 2) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = img[i]; img[i] = img[j]; img[j] = t;
            end
        end
    endtask

    task automatic build_model();
        int hist [256];
        int cdf  [256];
        int run, cmin, v;
        longint q;
        for (int i = 0; i < 256; i++) hist[i] = 0;
        for (int k = 0; k < N; k++) hist[img[k]]++;
        run = 0; cmin = -1;
        for (int i = 0; i < 256; i++) begin
            run += hist[i];
            cdf[i] = run;
            if (cmin < 0 && hist[i] != 0) cmin = run;
        end
        for (int k = 0; k < N; k++) begin
            v = int'(img[k]);
            if (cmin == N) begin
                expv[k] = 8'(v);
            end else begin
                q = longint'(cdf[v] - cmin) * 255 / longint'(N - cmin);
                expv[k] = (q > 255) ? 8'd255 : 8'(q);
            end
        end
    endtask

    // Pixel k is held on veri_i for the whole of input window k.
    task automatic send_image(input int stop_at);
        check_eq("veri_al_before_en", 32'(al), 1);
        en = 1'b1; vin = img[0];
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k < N; k++) begin
            vin = img[k];
            if (k == stop_at) begin
                repeat (3) @(posedge clk);
                #3 rst = 1'b1;
                #1 check_reset_outputs("rst_recv");
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (k == N - 1) begin
                repeat (INS) @(posedge clk);
                #1 check_eq("veri_al_at_last_capture", 32'(al), 1);
                @(posedge clk);
                #1 check_eq("veri_al_after_last_capture", 32'(al), 0);
            end else begin
                repeat (INP) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic receive_output(input int abort_after);
        int t, p, tend;
        t = 0;
        while (gonder !== 1'b1 && t < 25000) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("send_entry_within_budget", 32'(gonder), 1);
        if (gonder !== 1'b1) return;
        check_eq("bitti_rises_with_gonder", 32'(bitti), 1);
        tend = OF + (N - 1) * OP;
        for (t = 0; t < tend; t++) begin
            p = (t < OF) ? 0 : 1 + (t - OF) / OP;
            check_eq($sformatf("pix%0d_cyc%0d", p, t), 32'(vout), 32'(expv[p]));
            if (t == abort_after) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("rst_send");
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check_eq("done_gonder_low", 32'(gonder), 0);
        check_eq("done_bitti_high", 32'(bitti), 1);
        check_eq("done_veri_holds", 32'(vout), 32'(expv[N - 1]));
        @(posedge clk); #1;
        check_eq("idle_bitti_low", 32'(bitti), 0);
        check_eq("idle_veri_al", 32'(al), 1);
    endtask

    task automatic run_case(input string name, input int mode, input int rx_abort, input int tx_abort);
        fill(mode);
        build_model();
        send_image(rx_abort);
        if (rx_abort < 0) receive_output(tx_abort);
        $display("image %s checks=%0d errors=%0d", name, checks, errors);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vin = 8'd0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("power_on");
        rst = 1'b0;
        @(posedge clk); #1;

        run_case("const100", 0, -1, -1);
        run_case("mod4", 1, -1, -1);
        run_case("half0_255", 2, -1, -1);
        run_case("random_a", 3, -1, -1);
        run_case("random_b", 3, -1, -1);
        run_case("narrow", 4, -1, -1);
        run_case("abort_recv", 3, 20, -1);
        run_case("const50", 5, -1, -1);
        run_case("abort_send", 3, -1, 40);
        run_case("random_c", 3, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
